ntt_core_driver: RTL
====================

NTT_CORE_DRIVER -- requirements
Module: ntt_core_driver

Interface
REQ-001 Parameter DW, default 32: coefficient width; equals the core's `DATA_SIZE_ARB`.
REQ-002 Parameter PE, default 4: core PE count; the core output word is 2*PE*DW bits.
REQ-003 Parameter N, default 256: ring size, a power of two and a multiple of 2*PE.
REQ-004 Parameter GAP, default 5: idle cycles between the last fed coefficient and the start pulse.
REQ-005 Parameter TIMEOUT, default 65535: maximum number of WAIT cycles allowed for core_done.
REQ-006 Port clk, in, 1: the single clock; every register updates on the rising edge.
REQ-007 Port reset, in, 1: synchronous, active-low reset.
REQ-008 Port go, in, 1: single-cycle job request; sampled only in IDLE.
REQ-009 Ports s_valid (in, 1), s_ready (out, 1), s_data (in, DW): coefficient input stream from the host.
REQ-010 Port core_load_data, out, 1: load-data pulse to the NTT/INTT core.
REQ-011 Port core_start, out, 1: start pulse to the core.
REQ-012 Port core_din, out, DW: coefficient stream to the core.
REQ-013 Port core_done, in, 1: core completion flag.
REQ-014 Port core_dout, in, 2*PE*DW: core result word; lane n occupies bits [DW*n +: DW].
REQ-015 Ports m_valid (out, 1), m_ready (in, 1), m_data (out, DW), m_last (out, 1): result stream to the host.
REQ-016 Ports busy (out, 1), job_done (out, 1), err (out, 1): status outputs.

Function
REQ-017 The FSM SHALL have the states IDLE, FILL, LOADP, FEED, GAPW, STARTP, WAIT, CAPT, DRAIN and ERR.
REQ-018 IDLE + go=1 SHALL go to FILL, clear err, and clear all counters; go outside IDLE SHALL be ignored.
REQ-019 In FILL, s_ready SHALL be 1 and each s_valid&&s_ready beat SHALL write s_data to input buffer slot i (i=0..N-1); after beat N-1 the FSM SHALL go to LOADP.
REQ-020 LOADP SHALL last exactly 1 cycle with core_load_data=1 and core_din=0.
REQ-021 FEED SHALL last exactly N consecutive cycles and drive core_din=buffer[i] in cycle i, with no gaps; coefficient 0 appears in the cycle immediately after the LOADP cycle.
REQ-022 GAPW SHALL last GAP cycles with core_din=0; STARTP SHALL then last 1 cycle with core_start=1.
REQ-023 WAIT SHALL count cycles; the first cycle with core_done=1 SHALL go to CAPT; reaching TIMEOUT cycles without core_done SHALL go to ERR.
REQ-024 CAPT SHALL last N/(2*PE) cycles and store core_dout into output word m in its m-th cycle; the first CAPT cycle is the cycle after core_done is first seen high; core_done is not re-checked during CAPT.
REQ-025 DRAIN SHALL emit coefficient index k=2*PE*m+n as lane n of word m, in k order from 0 to N-1, on m_data.
REQ-026 m_valid SHALL be 1 throughout DRAIN; a beat is transferred when m_valid&&m_ready; m_data and m_last SHALL hold stable while m_ready=0.
REQ-027 m_last SHALL be 1 only with k=N-1; the transfer of that beat SHALL pulse job_done for 1 cycle (the following cycle) and return the FSM to IDLE.
REQ-028 ERR SHALL set err=1, deassert busy, and go to IDLE in the next cycle; err SHALL stay 1 until the next accepted go or reset.
REQ-029 busy SHALL be 1 in every state except IDLE and ERR.
REQ-030 s_ready SHALL be 0 outside FILL; m_valid SHALL be 0 outside DRAIN; core_load_data and core_start SHALL never both be 1.
REQ-031 A k counter wrap SHALL occur only at N-1→0, and only when leaving DRAIN.
REQ-032 The input and output buffers MAY share one N*DW memory; no FILL write may overwrite data still needed by DRAIN.

Reset
REQ-033 reset=0 at any clock edge SHALL force IDLE, clear all counters, and set busy, job_done, err, s_ready, m_valid, m_last, core_load_data, core_start and core_din to 0.
REQ-034 A reset mid-job SHALL abandon the job without a job_done pulse; buffer contents after reset are don't-care.

Verification (N=16, PE=2, GAP=5, DW=32)
REQ-035 Nominal: go, s_data=0..15 sent back-to-back → 1 core_load_data cycle, core_din=0..15 over 16 contiguous cycles, 5 idle cycles, 1 core_start cycle.
REQ-036 Capture order: core_done, then core_dout words {3,2,1,0}+4m for m=0..3 → m_data=0..15 in order, m_last on 15, job_done 1 cycle later.
REQ-037 Backpressure: s_valid toggling 50% and m_ready toggling 50% → the core-side timing is unchanged from REQ-035, and the output sequence is identical.
REQ-038 Timeout: TIMEOUT=100, core_done held 0 → err=1 after 100 WAIT cycles, busy=0, FSM in IDLE; the next go clears err.
REQ-039 Reset mid-FEED at coefficient 7 → all outputs 0 in the next cycle; a new job then completes correctly.
REQ-040 go during busy → ignored; exactly one job_done pulse is produced.

Source files
------------

// File: rtl/ntt_core_driver.sv
`default_nettype none
// ============================================================================
// ntt_core_driver : buffers one ring of coefficients, feeds an NTT/INTT core,
//                   captures its result and streams it back to the host.
// Revision        : 1.0
// ============================================================================
module ntt_core_driver #(
  parameter int DW      = 32,
  parameter int PE      = 4,
  parameter int N       = 256,
  parameter int GAP     = 5,
  parameter int TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DW-1:0]      s_data,
  output logic               core_load_data,
  output logic               core_start,
  output logic [DW-1:0]      core_din,
  input  logic               core_done,
  input  logic [2*PE*DW-1:0] core_dout,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DW-1:0]      m_data,
  output logic               m_last,
  output logic               busy,
  output logic               job_done,
  output logic               err
);

  localparam int LANES = 2 * PE;
  localparam int WORDS = N / LANES;
  localparam int AW    = $clog2(N);
  localparam int LW    = $clog2(LANES);
  localparam int RW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW    = $clog2(N + GAP + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FILL   = 4'd1,
    S_LOADP  = 4'd2,
    S_FEED   = 4'd3,
    S_GAPW   = 4'd4,
    S_STARTP = 4'd5,
    S_WAIT   = 4'd6,
    S_CAPT   = 4'd7,
    S_DRAIN  = 4'd8,
    S_ERR    = 4'd9
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     wcnt_q, wcnt_d;
  logic [AW-1:0]     k_q, k_d;
  logic              err_q, err_d;
  logic              job_done_q, job_done_d;
  logic              busy_q, s_ready_q, m_valid_q, m_last_q, load_q, start_q;
  logic [DW-1:0]     din_q;

  // One shared buffer, organised as core-width rows: FILL writes single lanes,
  // CAPT overwrites whole rows once FEED no longer needs the input ring.
  logic [LANES*DW-1:0] mem_q [WORDS];

  logic [AW-1:0] w_fill_idx;
  logic [RW-1:0] w_fill_row;
  logic [LW-1:0] w_fill_lane;
  logic [RW-1:0] w_capt_row;

  assign w_fill_idx  = cnt_q[AW-1:0];
  assign w_fill_row  = RW'(w_fill_idx >> LW);
  assign w_fill_lane = LW'(w_fill_idx);
  assign w_capt_row  = RW'(cnt_q);

  function automatic logic [DW-1:0] rd_coef(input logic [AW-1:0] idx);
    return mem_q[RW'(idx >> LW)][DW*int'(idx[LW-1:0]) +: DW];
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    k_d        = k_q;
    err_d      = err_q;
    job_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_FILL;
          cnt_d   = '0;
          wcnt_d  = '0;
          k_d     = '0;
          err_d   = 1'b0;
        end
      end
      S_FILL: begin
        if (s_valid && s_ready_q) begin
          if (cnt_q == CW'(N - 1)) begin
            state_d = S_LOADP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_LOADP: state_d = S_FEED;
      S_FEED: begin
        if (cnt_q == CW'(N - 1)) begin
          state_d = (GAP == 0) ? S_STARTP : S_GAPW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAPW: begin
        if (cnt_q == CW'(GAP - 1)) begin
          state_d = S_STARTP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STARTP: begin
        state_d = S_WAIT;
        wcnt_d  = '0;
      end
      S_WAIT: begin
        if (core_done) begin
          state_d = S_CAPT;
          cnt_d   = '0;
        end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_CAPT: begin
        if (cnt_q == CW'(WORDS - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          k_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (m_valid_q && m_ready) begin
          if (k_q == AW'(N - 1)) begin
            state_d    = S_IDLE;
            k_d        = '0;
            job_done_d = 1'b1;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ERR) err_d = 1'b1;
  end

  // Outputs are registered from the next-state decode so they align with state_q.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      k_q        <= '0;
      err_q      <= 1'b0;
      job_done_q <= 1'b0;
      busy_q     <= 1'b0;
      s_ready_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      load_q     <= 1'b0;
      start_q    <= 1'b0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wcnt_q     <= wcnt_d;
      k_q        <= k_d;
      err_q      <= err_d;
      job_done_q <= job_done_d;
      busy_q     <= (state_d != S_IDLE) && (state_d != S_ERR);
      s_ready_q  <= (state_d == S_FILL);
      m_valid_q  <= (state_d == S_DRAIN);
      m_last_q   <= (state_d == S_DRAIN) && (k_d == AW'(N - 1));
      load_q     <= (state_d == S_LOADP);
      start_q    <= (state_d == S_STARTP);
      din_q      <= (state_d == S_FEED) ? rd_coef(cnt_d[AW-1:0]) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_FILL && s_valid && s_ready_q) begin
      mem_q[w_fill_row][DW*int'(w_fill_lane) +: DW] <= s_data;
    end else if (state_q == S_CAPT) begin
      mem_q[w_capt_row] <= core_dout;
    end
  end

  assign s_ready        = s_ready_q;
  assign m_valid        = m_valid_q;
  assign m_last         = m_last_q;
  assign m_data         = m_valid_q ? rd_coef(k_q) : '0;
  assign core_load_data = load_q;
  assign core_start     = start_q;
  assign core_din       = din_q;
  assign busy           = busy_q;
  assign job_done       = job_done_q;
  assign err            = err_q;

endmodule
`default_nettype wire
